booth_sig_divider: RTL and testbench

//  Sequential radix-2 restoring divider for the FP significand datapath; inverse of the

---
 rtl/booth_sig_divider.sv | 138 +++++++++++++
 tb/tb_booth_sig_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_sig_divider.sv
// Sequential radix-2 restoring divider for FP significands: one quotient bit per clock,
// start/done handshake, remainder plus sticky for rounding, divide-by-zero flag.
module booth_sig_divider #(
   parameter int FRAC = 12,
   localparam int QW = 11 + FRAC,
   localparam int ITER = QW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [9:0]    a,
   input  logic          azero,
   input  logic [9:0]    b,
   input  logic          bzero,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] q,
   output logic [10:0]   r,
   output logic          sticky,
   output logic          dz
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e          state_q, state_d;
   logic [QW-1:0]   shiftX_q, shiftX_d;
   logic [10:0]     divisor_q, divisor_d;
   logic [10:0]     rem_q, rem_d;
   logic [QW-1:0]   quo_q, quo_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [QW-1:0]   qOut_q, qOut_d;
   logic [10:0]     rOut_q, rOut_d;
   logic            sticky_q, sticky_d;
   logic            dz_q, dz_d;

   logic [10:0]     dividend;
   logic [10:0]     divisorIn;
   logic [11:0]     trial;
   logic [11:0]     diff;
   logic            qBit;
   logic [10:0]     remNext;
   logic [QW-1:0]   quoNext;

   assign dividend  = {azero, a};
   assign divisorIn = {bzero, b};

   // Since rem < D, the trial value is below 2D and the difference always fits in 11 bits.
   assign trial   = {rem_q, shiftX_q[QW-1]};
   assign qBit    = (trial >= {1'b0, divisor_q});
   assign diff    = trial - {1'b0, divisor_q};
   assign remNext = qBit ? diff[10:0] : trial[10:0];
   assign quoNext = {quo_q[QW-2:0], qBit};

   always_comb begin
      state_d   = state_q;
      shiftX_d  = shiftX_q;
      divisor_d = divisor_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      qOut_d    = qOut_q;
      rOut_d    = rOut_q;
      sticky_d  = sticky_q;
      dz_d      = dz_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               if (divisorIn == 11'd0) begin
                  state_d  = DONE;
                  qOut_d   = '1;
                  rOut_d   = '0;
                  sticky_d = 1'b0;
                  dz_d     = 1'b1;
               end else begin
                  state_d   = RUN;
                  shiftX_d  = {dividend, {FRAC{1'b0}}};
                  divisor_d = divisorIn;
                  rem_d     = '0;
                  quo_d     = '0;
                  cnt_d     = CW'(ITER - 1);
                  dz_d      = 1'b0;
               end
            end
         end
         RUN: begin
            shiftX_d = shiftX_q << 1;
            rem_d    = remNext;
            quo_d    = quoNext;
            if (cnt_q == '0) begin
               state_d  = DONE;
               qOut_d   = quoNext;
               rOut_d   = remNext;
               sticky_d = |remNext;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         shiftX_q  <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         qOut_q    <= '0;
         rOut_q    <= '0;
         sticky_q  <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shiftX_q  <= shiftX_d;
         divisor_q <= divisor_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         qOut_q    <= qOut_d;
         rOut_q    <= rOut_d;
         sticky_q  <= sticky_d;
         dz_q      <= dz_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign q      = qOut_q;
   assign r      = rOut_q;
   assign sticky = sticky_q;
   assign dz     = dz_q;

endmodule

// File: tb/tb_booth_sig_divider.sv
// Self-checking bench for booth_sig_divider: directed corner cases, handshake, reset abort,
// and random operands against an arithmetic reference model.
module tb_booth_sig_divider;

   localparam int FRAC = 12;
   localparam int QW = 11 + FRAC;
   localparam int ITER = QW;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          start = 1'b0;
   logic [9:0]    a = '0;
   logic          azero = 1'b0;
   logic [9:0]    b = '0;
   logic          bzero = 1'b0;
   logic          busy;
   logic          done;
   logic [QW-1:0] q;
   logic [10:0]   r;
   logic          sticky;
   logic          dz;

   int errors = 0;
   int checks = 0;

   logic [QW-1:0] expQ;
   logic [10:0]   expR;
   logic          expS;
   logic          expDz;

   booth_sig_divider #(.FRAC(FRAC)) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .a(a), .azero(azero), .b(b), .bzero(bzero),
      .busy(busy), .done(done), .q(q), .r(r), .sticky(sticky), .dz(dz)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: quotient and remainder of the scaled dividend by plain integer division.
   task automatic refModel(input logic [10:0] n, input logic [10:0] d,
                           output logic [QW-1:0] eq, output logic [10:0] er,
                           output logic es, output logic edz);
      longint unsigned num;
      num = longint'(n) << FRAC;
      if (d == 11'd0) begin
         eq = '1; er = '0; es = 1'b0; edz = 1'b1;
      end else begin
         eq  = QW'(num / longint'(d));
         er  = 11'(num % longint'(d));
         es  = (er != 11'd0);
         edz = 1'b0;
      end
   endtask

   // Called at posedge+1; start is sampled at the next edge (E0), returns at E0+1.
   task automatic applyStimulus(input logic [9:0] aa, input logic az,
                                input logic [9:0] bb, input logic bz);
      a = aa; azero = az; b = bb; bzero = bz;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(output int n);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      if (done !== 1'b1) checkOutput("timeout", {63'd0, done}, 64'd1);
   endtask

   task automatic checkResult(input string tag);
      checkOutput({tag, ".q"}, 64'(q), 64'(expQ));
      checkOutput({tag, ".r"}, 64'(r), 64'(expR));
      checkOutput({tag, ".sticky"}, 64'(sticky), 64'(expS));
      checkOutput({tag, ".dz"}, 64'(dz), 64'(expDz));
   endtask

   task automatic runOp(input string tag, input logic [9:0] aa, input logic az,
                        input logic [9:0] bb, input logic bz);
      int n;
      refModel({az, aa}, {bz, bb}, expQ, expR, expS, expDz);
      applyStimulus(aa, az, bb, bz);
      checkOutput({tag, ".busy"}, 64'(busy), 64'(!expDz));
      waitDone(n);
      checkOutput({tag, ".latency"}, 64'(n), expDz ? 64'd0 : 64'(ITER));
      checkResult(tag);
      @(posedge CLK); #1;
      checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      int n2;
      logic [QW-1:0] holdQ;
      logic [10:0]   holdR;
      logic [QW-1:0] bQ;
      logic [10:0]   bR;
      logic          bS;
      logic          bDz;
      logic [9:0]    ra;
      logic [9:0]    rb;
      logic          raz;
      logic          rbz;

      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset.busy", 64'(busy), 64'd0);
      checkOutput("reset.done", 64'(done), 64'd0);
      checkOutput("reset.q", 64'(q), 64'd0);
      checkOutput("reset.r", 64'(r), 64'd0);
      checkOutput("reset.sticky", 64'(sticky), 64'd0);
      checkOutput("reset.dz", 64'(dz), 64'd0);
      RST = 1'b1;
      @(posedge CLK); #1;

      runOp("div1p5by1", 10'h200, 1'b1, 10'h000, 1'b1);
      checkOutput("div1p5by1.golden", 64'(q), 64'h001800);
      runOp("div1by1p5", 10'h000, 1'b1, 10'h200, 1'b1);
      checkOutput("div1by1p5.golden", 64'(r), 64'h400);
      runOp("maxQuot", 10'h3FF, 1'b1, 10'h001, 1'b0);
      checkOutput("maxQuot.golden", 64'(q), 64'h7FF000);
      runOp("divZero", 10'h2A5, 1'b1, 10'h000, 1'b0);
      checkOutput("divZero.golden", 64'(q), 64'h7FFFFF);
      runOp("zeroDividend", 10'h000, 1'b0, 10'h123, 1'b1);

      // A second start during RUN must be ignored and leave held outputs untouched.
      holdQ = expQ; holdR = expR;
      refModel({1'b1, 10'h155}, {1'b1, 10'h0AB}, expQ, expR, expS, expDz);
      applyStimulus(10'h155, 1'b1, 10'h0AB, 1'b1);
      repeat (4) begin @(posedge CLK); #1; end
      checkOutput("ignore.busy", 64'(busy), 64'd1);
      a = 10'h3C3; azero = 1'b0; b = 10'h011; bzero = 1'b0; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      checkOutput("ignore.qHeld", 64'(q), 64'(holdQ));
      checkOutput("ignore.rHeld", 64'(r), 64'(holdR));
      waitDone(n);
      checkOutput("ignore.latency", 64'(n + 5), 64'(ITER));
      checkResult("ignore");

      // Start held high through DONE launches the next operation back-to-back.
      @(posedge CLK); #1;
      refModel({1'b0, 10'h3A7}, {1'b1, 10'h1F0}, expQ, expR, expS, expDz);
      refModel({1'b1, 10'h0F1}, {1'b0, 10'h2C9}, bQ, bR, bS, bDz);
      a = 10'h3A7; azero = 1'b0; b = 10'h1F0; bzero = 1'b1; start = 1'b1;
      @(posedge CLK); #1;
      a = 10'h0F1; azero = 1'b1; b = 10'h2C9; bzero = 1'b0;
      waitDone(n);
      checkOutput("b2b.first.latency", 64'(n), 64'(ITER));
      checkResult("b2b.first");
      @(posedge CLK); #1;
      start = 1'b0;
      checkOutput("b2b.busy", 64'(busy), 64'd1);
      checkOutput("b2b.qHeld", 64'(q), 64'(expQ));
      waitDone(n2);
      checkOutput("b2b.spacing", 64'(n2 + 1), 64'(ITER + 1));
      expQ = bQ; expR = bR; expS = bS; expDz = bDz;
      checkResult("b2b.second");
      @(posedge CLK); #1;

      // Asynchronous reset in the middle of a run clears everything immediately.
      applyStimulus(10'h200, 1'b1, 10'h000, 1'b1);
      repeat (10) begin @(posedge CLK); #1; end
      RST = 1'b0;
      #1;
      checkOutput("abort.busy", 64'(busy), 64'd0);
      checkOutput("abort.done", 64'(done), 64'd0);
      checkOutput("abort.q", 64'(q), 64'd0);
      checkOutput("abort.r", 64'(r), 64'd0);
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("abort.noDone", 64'(done), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      runOp("afterAbort", 10'h200, 1'b1, 10'h000, 1'b1);

      for (int i = 0; i < 16; i++) begin
         ra  = 10'($urandom);
         rb  = 10'($urandom);
         raz = 1'($urandom);
         rbz = 1'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rb = '0; rbz = 1'b0;
         end
         runOp($sformatf("rand%0d", i), ra, raz, rb, rbz);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
